hall_conditioner: RTL and testbench
===================================

HALL_CONDITIONER -- requirements
Module: hall_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable clocks needed to accept a new hall code (legal range 2..255).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 16, meaning the width of the commutation-period counter.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port hall_raw, input, 3 bits: unsynchronised hall sensor pins.
REQ-006 SHALL have port fault_clr, input, 1 bit: clears sticky faults.
REQ-007 SHALL have port hall_out, output, 3 bits: filtered hall code; feeds the motor driver h input.
REQ-008 SHALL have port hall_valid, output, 1 bit: hall_out holds an accepted legal code.
REQ-009 SHALL have port commutate, output, 1 bit: one-clock pulse per legal accepted transition.
REQ-010 SHALL have port dir_measured, output, 1 bit: 0 = forward, 1 = reverse.
REQ-011 SHALL have port period, output, PERIOD_WIDTH bits: clocks between the last two commutations.
REQ-012 SHALL have port period_valid, output, 1 bit: one-clock pulse when period updates.
REQ-013 SHALL have port stall, output, 1 bit: period counter saturated.
REQ-014 SHALL have port hall_fault, output, 1 bit: sticky illegal-code or sequence fault.

Function
REQ-015 SHALL pass hall_raw through a 2-flop synchroniser before any other use.
REQ-016 SHALL accept a synchronised code only after it is unchanged for DEBOUNCE_CYCLES consecutive clocks; any change restarts the count.
- Latency: hall_out updates on edge DEBOUNCE_CYCLES+2 after the first edge that samples the new raw value.
REQ-017 SHALL treat codes 001, 011, 010, 110, 100, 101 as legal, and 000 and 111 as illegal.
REQ-018 SHALL define the forward sequence as 001→011→010→110→100→101→001; reverse is the inverse.
REQ-019 SHALL, on an accepted illegal code:
- hold hall_out at the last legal code;
- clear hall_valid;
- set hall_fault;
- emit no commutate.
REQ-020 SHALL, on the first accepted legal code after reset or after an illegal code, update hall_out and set hall_valid, with no commutate, no period_valid, and the period counter cleared.
REQ-021 SHALL, on an accepted legal code adjacent to the previous one, update hall_out, pulse commutate, and set dir_measured to 0 for a forward step or 1 for a reverse step.
REQ-022 SHALL increment the period counter every clock, saturating at all-ones and never wrapping.
REQ-023 SHALL, on commutate, load period with the counter value, pulse period_valid in the same cycle as commutate, and clear the counter to 0.
REQ-024 SHALL assert stall while the counter is saturated and deassert it on the next commutate or counter clear.
REQ-025 SHALL clear hall_fault on fault_clr, unless a new fault is detected in the same cycle, in which case set wins.
REQ-026 SHALL leave dir_measured unchanged when no legal adjacent transition occurs.

Reset
REQ-027 SHALL force all state to reset values asynchronously when reset_n is low.
- Reset values: hall_out=000, hall_valid=0, commutate=0, dir_measured=0, period=0, period_valid=0, stall=0, hall_fault=0.
- Synchroniser flops, debounce counter and period counter also reset to 0.
REQ-028 SHALL, on reset mid-debounce, discard the partially counted code.

Configuration
REQ-029 SHALL implement sequence checking when HALL_SEQ_CHECK_EN is defined: an accepted legal code that is neither next nor previous in sequence updates hall_out, sets hall_fault, emits no commutate/period_valid, and clears the period counter.
REQ-030 SHALL, without HALL_SEQ_CHECK_EN, treat any legal-to-different-legal transition as a commutation; direction is updated only for adjacent steps.

Structure
REQ-031 SHALL place the legal hall code constants, the next-code and previous-code lookup functions, and the default DEBOUNCE_CYCLES in shared package hall_pkg.
REQ-032 SHALL implement synchroniser plus debounce as sub-module hall_debounce (3-bit input, accepted code plus one-clock accept strobe out), instantiated once.

Verification
REQ-033 SHALL verify: raw 001 held after reset, DEBOUNCE_CYCLES=16 → hall_out=001 on edge 18, hall_valid=1, no commutate.
REQ-034 SHALL verify: 001→011 glitch lasting 10 clocks then back to 001 → hall_out stays 001, no commutate.
REQ-035 SHALL verify: forward sequence at 1000-clock steps → commutate each step, dir_measured=0, period=1000 from the second step onward.
REQ-036 SHALL verify: accepted 111 → hall_valid=0, hall_fault=1, hall_out holds; fault_clr while 111 persists → hall_fault stays cleared (no new accept); next legal code sets hall_valid with no commutate.
REQ-037 SHALL verify: PERIOD_WIDTH=8 and no transition for 300 clocks → stall=1 with counter held at 255; next commutate → period=255, stall=0.
REQ-038 SHALL verify, with HALL_SEQ_CHECK_EN: 001→010 → hall_fault=1, hall_out=010, no commutate; without the macro → commutate pulse and no fault.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared hall-sensor definitions: legal code constants, commutation order
// lookups and the default debounce length.
package hall_pkg;

  localparam int unsigned HALL_W           = 3;
  localparam int unsigned DEBOUNCE_DEFAULT = 16;

  typedef logic [HALL_W-1:0] hall_code_t;

  // Forward commutation order: A -> B -> C -> D -> E -> F -> A
  localparam hall_code_t HALL_A = 3'b001;
  localparam hall_code_t HALL_B = 3'b011;
  localparam hall_code_t HALL_C = 3'b010;
  localparam hall_code_t HALL_D = 3'b110;
  localparam hall_code_t HALL_E = 3'b100;
  localparam hall_code_t HALL_F = 3'b101;

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } hall_state_t;

  function automatic logic is_legal(hall_code_t c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  function automatic hall_code_t next_code(hall_code_t c);
    hall_code_t r;
    case (c)
      HALL_A:  r = HALL_B;
      HALL_B:  r = HALL_C;
      HALL_C:  r = HALL_D;
      HALL_D:  r = HALL_E;
      HALL_E:  r = HALL_F;
      HALL_F:  r = HALL_A;
      default: r = c;
    endcase
    return r;
  endfunction

  function automatic hall_code_t prev_code(hall_code_t c);
    hall_code_t r;
    case (c)
      HALL_A:  r = HALL_F;
      HALL_B:  r = HALL_A;
      HALL_C:  r = HALL_B;
      HALL_D:  r = HALL_C;
      HALL_E:  r = HALL_D;
      HALL_F:  r = HALL_E;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser followed by a stability filter. accept_c is high for
// exactly one clock when the synchronised code has been seen on
// DEBOUNCE_CYCLES consecutive edges; code holds that candidate.
module hall_debounce
  import hall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       raw,
  output hall_code_t       code,
  output logic             accept_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

  hall_code_t       sync1;
  hall_code_t       sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then count consecutive identical samples of sync2
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      code  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != code) begin
        code <= sync2;
        cnt  <= CNT_W'(1);
      end else if (cnt < CNT_SAT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Fires on the edge that would record the final stable sample
  assign accept_c = (sync2 == code) && (cnt == ACCEPT_AT);

endmodule

// File: rtl/hall_conditioner.sv
// Hall sensor conditioner: debounce, legality/sequence checking, direction
// and commutation-period measurement.
// Optional feature: define HALL_SEQ_CHECK_EN to flag non-adjacent legal steps
// as faults instead of commutations.
module hall_conditioner
  import hall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned PERIOD_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2:0]              hall_raw,
  input  logic                    fault_clr,
  output logic [2:0]              hall_out,
  output logic                    hall_valid,
  output logic                    commutate,
  output logic                    dir_measured,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stall,
  output logic                    hall_fault
);

  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

  hall_code_t              code;
  logic                    accept_c;
  hall_state_t             state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]              hall_out_d;
  logic                    valid_d, commutate_d, dir_d, period_valid_d;
  logic                    stall_d, fault_d;
  logic [PERIOD_WIDTH-1:0] period_d;
  logic                    step_fwd, step_rev, step_ok;

  hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset_n  (reset_n),
    .raw      (hall_raw),
    .code     (code),
    .accept_c (accept_c)
  );

  assign step_fwd = (code == next_code(hall_out));
  assign step_rev = (code == prev_code(hall_out));
`ifdef HALL_SEQ_CHECK_EN
  assign step_ok  = step_fwd | step_rev;
`else
  assign step_ok  = 1'b1;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_WIDTH'(1);

  // State register plus all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_UNLOCKED;
      cnt_q        <= '0;
      hall_out     <= '0;
      hall_valid   <= 1'b0;
      commutate    <= 1'b0;
      dir_measured <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      hall_fault   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hall_out     <= hall_out_d;
      hall_valid   <= valid_d;
      commutate    <= commutate_d;
      dir_measured <= dir_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      stall        <= stall_d;
      hall_fault   <= fault_d;
    end
  end

  // Next state and output decode on each accepted code
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_inc;
    hall_out_d     = hall_out;
    valid_d        = hall_valid;
    commutate_d    = 1'b0;
    dir_d          = dir_measured;
    period_d       = period;
    period_valid_d = 1'b0;
    fault_d        = hall_fault & ~fault_clr;

    if (accept_c) begin
      if (!is_legal(code)) begin
        state_d = ST_UNLOCKED;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end else if (state_q == ST_UNLOCKED) begin
        state_d    = ST_LOCKED;
        hall_out_d = code;
        valid_d    = 1'b1;
        cnt_d      = '0;
      end else if (code != hall_out) begin
        hall_out_d = code;
        cnt_d      = '0;
        if (step_ok) begin
          commutate_d    = 1'b1;
          period_valid_d = 1'b1;
          period_d       = cnt_inc;
          if (step_fwd) begin
            dir_d = 1'b0;
          end else if (step_rev) begin
            dir_d = 1'b1;
          end
        end else begin
          fault_d = 1'b1;
        end
      end
    end

    stall_d = (cnt_d == CNT_MAX);
  end

endmodule

// File: tb/tb_hall_conditioner.sv
// Scoreboard bench for hall_conditioner. A second instance with an 8-bit
// period counter exercises saturation/stall on the same stimulus.
// Expectations follow HALL_SEQ_CHECK_EN when it is defined.
module tb_hall_conditioner;

`ifdef HALL_SEQ_CHECK_EN
  localparam bit SEQ_CHECK = 1'b1;
`else
  localparam bit SEQ_CHECK = 1'b0;
`endif
  localparam int LAT = 18;  // DEBOUNCE_CYCLES(16) + 2

  typedef struct packed {
    logic [2:0]  hall;
    logic        valid;
    logic        comm;
    logic        dir;
    logic        fault;
    logic [15:0] period;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fault_clr;
  logic [2:0]  hall_raw;

  logic [2:0]  hall_out;
  logic        hall_valid, commutate, dir_measured, period_valid, stall, hall_fault;
  logic [15:0] period;

  logic [2:0]  hall_out_8;
  logic        hall_valid_8, commutate_8, dir_8, period_valid_8, stall_8, hall_fault_8;
  logic [7:0]  period_8;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // model state
  logic [2:0]  m_hall = 3'b000;
  logic        m_valid = 1'b0, m_dir = 1'b0, m_fault = 1'b0, m_locked = 1'b0;
  logic [15:0] m_period = '0;
  int          m_clear = 0;

  hall_conditioner dut (
    .clock(clock), .reset_n(reset_n), .hall_raw(hall_raw), .fault_clr(fault_clr),
    .hall_out(hall_out), .hall_valid(hall_valid), .commutate(commutate),
    .dir_measured(dir_measured), .period(period), .period_valid(period_valid),
    .stall(stall), .hall_fault(hall_fault)
  );

  hall_conditioner #(.PERIOD_WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .hall_raw(hall_raw), .fault_clr(fault_clr),
    .hall_out(hall_out_8), .hall_valid(hall_valid_8), .commutate(commutate_8),
    .dir_measured(dir_8), .period(period_8), .period_valid(period_valid_8),
    .stall(stall_8), .hall_fault(hall_fault_8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int seq_idx(logic [2:0] c);
    case (c)
      3'b001: return 0;
      3'b011: return 1;
      3'b010: return 2;
      3'b110: return 3;
      3'b100: return 4;
      3'b101: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic push_exp(input logic comm, input int ec);
    exp_t e;
    e.hall = m_hall; e.valid = m_valid; e.comm = comm; e.dir = m_dir;
    e.fault = m_fault; e.period = m_period; e.cyc = ec;
    exp_q.push_back(e);
  endtask

  // Drive a raw code at a negedge, predict the accepted outcome, then hold
  task automatic apply_code(input logic [2:0] c, input int hold);
    int ec, ic, ih;
    logic fwd, rev;
    if (m_locked) begin
      check("stall_16bit", 32'(stall), 0);
      check("stall_8bit_held", 32'(stall_8), 1);
    end
    ec = cyc + LAT;
    hall_raw = c;
    ic = seq_idx(c);
    ih = seq_idx(m_hall);
    if (ic < 0) begin
      m_valid = 1'b0; m_fault = 1'b1; m_locked = 1'b0;
      push_exp(1'b0, ec);
    end else if (!m_locked) begin
      m_locked = 1'b1; m_hall = c; m_valid = 1'b1; m_clear = ec;
      push_exp(1'b0, ec);
    end else if (c != m_hall) begin
      fwd = (ic == (ih + 1) % 6);
      rev = (ih == (ic + 1) % 6);
      m_hall = c;
      if (SEQ_CHECK && !(fwd || rev)) begin
        m_fault = 1'b1; m_clear = ec;
        push_exp(1'b0, ec);
      end else begin
        m_period = (ec - m_clear > 65535) ? 16'hFFFF : 16'(ec - m_clear);
        if (fwd) m_dir = 1'b0;
        else if (rev) m_dir = 1'b1;
        m_clear = ec;
        push_exp(1'b1, ec);
      end
    end
    repeat (hold) @(negedge clock);
  endtask

  // Monitor: any change of observable state is an event matched to the queue
  logic [2:0]  p_hall = '0;
  logic        p_valid = 1'b0, p_dir = 1'b0, p_fault = 1'b0;
  always @(negedge clock) begin
    if (reset_n) begin
      if (commutate || period_valid || hall_out != p_hall || hall_valid != p_valid ||
          dir_measured != p_dir || hall_fault != p_fault) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(hall_out), 32'(p_hall ^ 3'b111) & 32'h0 | 32'hFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("hall_out", 32'(hall_out), 32'(e.hall));
          check("hall_valid", 32'(hall_valid), 32'(e.valid));
          check("commutate", 32'(commutate), 32'(e.comm));
          check("period_valid", 32'(period_valid), 32'(e.comm));
          check("dir_measured", 32'(dir_measured), 32'(e.dir));
          check("hall_fault", 32'(hall_fault), 32'(e.fault));
          check("period", 32'(period), 32'(e.period));
        end
      end
      p_hall = hall_out; p_valid = hall_valid; p_dir = dir_measured; p_fault = hall_fault;
    end
  end

  // 8-bit instance always commutates after long holds: saturated period, stall released
  always @(negedge clock) begin
    if (reset_n && commutate_8) begin
      check("period_8bit_sat", 32'(period_8), 255);
      check("stall_8bit_release", 32'(stall_8), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    fault_clr = 1'b0;
    hall_raw  = 3'b001;
    repeat (3) @(negedge clock);
    check("rst_hall_out", 32'(hall_out), 0);
    check("rst_hall_valid", 32'(hall_valid), 0);
    check("rst_commutate", 32'(commutate), 0);
    check("rst_dir", 32'(dir_measured), 0);
    check("rst_period", 32'(period), 0);
    check("rst_period_valid", 32'(period_valid), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_hall_fault", 32'(hall_fault), 0);

    // first legal code after reset: raw already 001, accepted on edge 18
    reset_n = 1'b1;
    m_locked = 1'b1; m_hall = 3'b001; m_valid = 1'b1; m_clear = cyc + LAT;
    push_exp(1'b0, cyc + LAT);
    repeat (1000) @(negedge clock);

    // 10-clock glitch to 011 must not be accepted
    hall_raw = 3'b011;
    repeat (10) @(negedge clock);
    hall_raw = 3'b001;
    repeat (1000) @(negedge clock);

    // full forward revolution at 1000-clock steps
    apply_code(3'b011, 1000);
    apply_code(3'b010, 1000);
    apply_code(3'b110, 1000);
    apply_code(3'b100, 1000);
    apply_code(3'b101, 1000);
    apply_code(3'b001, 1000);

    // single reverse step
    apply_code(3'b101, 1000);

    // illegal code, then fault_clr while it persists
    apply_code(3'b111, 1000);
    fault_clr = 1'b1;
    m_fault = 1'b0;
    push_exp(1'b0, cyc + 1);
    @(negedge clock);
    fault_clr = 1'b0;
    repeat (300) @(negedge clock);

    // recovery to a legal code: no commutate, counter restarts
    apply_code(3'b001, 1000);

    // skip step 001 -> 010
    apply_code(3'b010, 1000);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
